decode_stage: RTL

Clocked instruction-decode stage directly downstream of the instruction fetch stage. Accepts one assembled 32-bit ARM (ARMv4) instruction word plus its address per handshake. Classifies the word, extracts register and immediate fields, and computes branch targets. Buffers results in a 2-entry output queue so `in_ready` is a registered signal and back-pressure never forms a combinational path to fetch.

---
 rtl/arm_pkg.sv | 60 ++++++
 rtl/arm_decoder.sv | 62 ++++++
 rtl/decode_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARMv4 decode types: instruction classes, condition codes and the
// decoded-instruction record carried through the decode queue.
package arm_pkg;

    typedef enum logic [2:0] {
        CLS_DP    = 3'd0,
        CLS_MUL   = 3'd1,
        CLS_LDST  = 3'd2,
        CLS_LDSTM = 3'd3,
        CLS_BR    = 3'd4,
        CLS_SWI   = 3'd5,
        CLS_UNDEF = 3'd7
    } instr_class_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef struct packed {
        logic [31:0]  pc;
        logic [3:0]   cond;
        instr_class_e cls;
        logic [3:0]   opcode;
        logic         s;
        logic [3:0]   rn;
        logic [3:0]   rd;
        logic [3:0]   rs;
        logic [3:0]   rm;
        logic         imm_flag;
        logic [31:0]  imm32;
        logic         link;
        logic [31:0]  target;
    } decoded_t;

    localparam decoded_t DECODED_RESET = '{
        pc: 32'd0, cond: 4'd0, cls: CLS_UNDEF, opcode: 4'd0, s: 1'b0,
        rn: 4'd0, rd: 4'd0, rs: 4'd0, rm: 4'd0, imm_flag: 1'b0,
        imm32: 32'd0, link: 1'b0, target: 32'd0
    };

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
        logic [63:0] vv;
        vv = {v, v} >> amt;
        return vv[31:0];
    endfunction

endpackage

// File: rtl/arm_decoder.sv
// Combinational ARMv4 instruction classifier and field extractor.
module arm_decoder
    import arm_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output decoded_t    dec_o
);

    instr_class_e cls;
    logic [31:0]  br_off;

    // Classification is priority ordered: the first matching pattern wins.
    always_comb begin
        if (instr_i[31:28] == COND_NV)                               cls = CLS_UNDEF;
        else if (instr_i[27:25] == 3'b101)                           cls = CLS_BR;
        else if (instr_i[27:24] == 4'b1111)                          cls = CLS_SWI;
        else if (instr_i[27:22] == 6'b0 && instr_i[7:4] == 4'b1001)  cls = CLS_MUL;
        else if (instr_i[27:25] == 3'b011 && instr_i[4])             cls = CLS_UNDEF;
        else if (instr_i[27:26] == 2'b01)                            cls = CLS_LDST;
        else if (instr_i[27:25] == 3'b100)                           cls = CLS_LDSTM;
        else if (instr_i[27:26] == 2'b00)                            cls = CLS_DP;
        else                                                         cls = CLS_UNDEF;
    end

    assign br_off = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};

    always_comb begin
        dec_o          = DECODED_RESET;
        dec_o.pc       = pc_i;
        dec_o.cond     = instr_i[31:28];
        dec_o.cls      = cls;
        dec_o.opcode   = instr_i[24:21];
        dec_o.s        = instr_i[20];
        dec_o.rn       = instr_i[19:16];
        dec_o.rd       = instr_i[15:12];
        dec_o.rs       = instr_i[11:8];
        dec_o.rm       = instr_i[3:0];
        dec_o.imm_flag = instr_i[25];

        case (cls)
            CLS_MUL: begin
                dec_o.rd = instr_i[19:16];
                dec_o.rn = instr_i[15:12];
            end
            CLS_DP: begin
                if (instr_i[25])
                    dec_o.imm32 = ror32({24'd0, instr_i[7:0]}, {instr_i[11:8], 1'b0});
            end
            CLS_LDST: begin
                if (!instr_i[25])
                    dec_o.imm32 = {20'd0, instr_i[11:0]};
            end
            CLS_BR: begin
                dec_o.link   = instr_i[24];
                dec_o.target = pc_i + 32'd8 + br_off;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes each accepted fetch word and buffers the result in a
// small FIFO so that in_ready is registered and never sees out_ready directly.
module decode_stage
    import arm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_cond,
    output logic [2:0]  out_class,
    output logic [3:0]  out_opcode,
    output logic        out_s,
    output logic [3:0]  out_rn,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs,
    output logic [3:0]  out_rm,
    output logic        out_imm_flag,
    output logic [31:0] out_imm32,
    output logic        out_link,
    output logic [31:0] out_target
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    decoded_t             dec;
    decoded_t             mem_q [DEPTH];
    decoded_t             head;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic                 in_ready_q, in_ready_d;
    logic                 push, pop;

    arm_decoder u_decoder (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .dec_o   (dec)
    );

    assign push = in_valid && in_ready_q && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        count_d    = count_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        if (flush) begin
            count_d = '0;
            wr_d    = '0;
            rd_d    = '0;
        end else begin
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Entries reset too, so the outputs show a defined record after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DECODED_RESET;
        end else if (push) begin
            mem_q[wr_q] <= dec;
        end
    end

    assign head         = mem_q[rd_q];
    assign in_ready     = in_ready_q;
    assign out_valid    = (count_q != '0);
    assign out_pc       = head.pc;
    assign out_cond     = head.cond;
    assign out_class    = head.cls;
    assign out_opcode   = head.opcode;
    assign out_s        = head.s;
    assign out_rn       = head.rn;
    assign out_rd       = head.rd;
    assign out_rs       = head.rs;
    assign out_rm       = head.rm;
    assign out_imm_flag = head.imm_flag;
    assign out_imm32    = head.imm32;
    assign out_link     = head.link;
    assign out_target   = head.target;

endmodule
